// File: rtl/half_norm_pack.sv
// Normalizes a raw sign/exponent/significand result, rounds to nearest-even, packs binary16.
// Latency: out_valid N+3 cycles after start is sampled (N = shift cycles), 2 cycles for a zero result.
// No backpressure: start is accepted only in IDLE; a start seen while busy is dropped, not queued.
module half_norm_pack #(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_sign,
    input  logic [EXP_W-1:0]          in_expo,
    input  logic [FRAC_W+3:0]         in_sig,
    input  logic                      in_sticky,
    output logic                      busy,
    output logic                      out_valid,
    output logic [EXP_W+FRAC_W:0]     out
);

    localparam int SIG_W = FRAC_W + 4;
    localparam int HID   = FRAC_W + 2;
    localparam int CARRY = FRAC_W + 3;
    localparam int PK_W  = EXP_W + FRAC_W;

    localparam logic [EXP_W:0]   EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0]   EXP_LIM = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W-1:0] EF_MAX  = {EXP_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic               sgn;
    logic [EXP_W:0]     expo;
    logic [SIG_W-1:0]   sig;
    logic               sticky;

    logic [EXP_W-1:0]   efield;
    logic               inc;
    logic [PK_W-1:0]    sum;
    logic [PK_W:0]      round_word;

    assign busy = (state != IDLE);

    // Rounding: the fraction carry ripples straight into the exponent field,
    // which also promotes a subnormal to the smallest normal.
    always_comb begin
        efield     = sig[HID] ? expo[EXP_W-1:0] : {EXP_W{1'b0}};
        inc        = sig[1] & (sig[0] | sticky | sig[2]);
        sum        = {efield, sig[FRAC_W+1:2]} + {{(PK_W-1){1'b0}}, inc};
        round_word = {sgn, sum};
        if (expo >= EXP_LIM || sum[PK_W-1:FRAC_W] == EF_MAX) begin
            round_word = {sgn, EF_MAX, {FRAC_W{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sgn       <= 1'b0;
            expo      <= '0;
            sig       <= '0;
            sticky    <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sgn    <= in_sign;
                        expo   <= (in_expo == '0) ? EXP_ONE : {1'b0, in_expo};
                        sig    <= in_sig;
                        sticky <= in_sticky;
                        state  <= NORM;
                    end
                end
                NORM: begin
                    if (sig == '0 && !sticky) begin
                        out   <= {sgn, {PK_W{1'b0}}};
                        state <= DONE;
                    end else if (sig[CARRY]) begin
                        sig    <= sig >> 1;
                        sticky <= sticky | sig[0];
                        expo   <= expo + EXP_ONE;
                    end else if (!sig[HID] && expo > EXP_ONE) begin
                        sig  <= sig << 1;
                        expo <= expo - EXP_ONE;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    out   <= round_word;
                    state <= DONE;
                end
                DONE: begin
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_half_norm_pack.sv
// Directed bench for half_norm_pack: packed result, latency, single-pulse and reset abort.
module tb_half_norm_pack;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_sign;
    logic [4:0]  in_expo;
    logic [13:0] in_sig;
    logic        in_sticky;
    logic        busy;
    logic        out_valid;
    logic [15:0] out;

    int n_checks = 0;
    int n_errors = 0;

    half_norm_pack dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_sign   (in_sign),
        .in_expo   (in_expo),
        .in_sig    (in_sig),
        .in_sticky (in_sticky),
        .busy      (busy),
        .out_valid (out_valid),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation and check result, latency and that the pulse lasts one cycle.
    task automatic run_op(input string tag, input logic s, input logic [4:0] e,
                          input logic [13:0] sg, input logic st,
                          input logic [15:0] exp_out, input int exp_lat);
        int lat;
        @(negedge clk);
        in_sign = s; in_expo = e; in_sig = sg; in_sticky = st; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_out"}, {16'd0, out}, {16'd0, exp_out});
        @(posedge clk);
        #1 check({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; start = 1'b0; in_sign = 1'b0; in_expo = '0; in_sig = '0; in_sticky = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_vld",  {31'd0, out_valid}, 32'd0);
        check("rst_out",  {16'd0, out}, 32'd0);
        rst = 1'b0;

        run_op("one",      1'b0, 5'd15, 14'h1000, 1'b0, 16'h3C00, 3);
        run_op("carry",    1'b0, 5'd15, 14'h3000, 1'b0, 16'h4200, 4);
        run_op("ovf_inf",  1'b1, 5'd30, 14'h2000, 1'b0, 16'hFC00, 4);
        run_op("lshift2",  1'b0, 5'd15, 14'h0400, 1'b0, 16'h3400, 5);
        run_op("subnorm",  1'b0, 5'd1,  14'h0800, 1'b0, 16'h0200, 3);
        run_op("rne_up",   1'b0, 5'd15, 14'h1FFE, 1'b0, 16'h4000, 3);
        run_op("rne_tie",  1'b0, 5'd15, 14'h1002, 1'b0, 16'h3C00, 3);
        run_op("rne_stk",  1'b0, 5'd15, 14'h1002, 1'b1, 16'h3C01, 3);
        run_op("negzero",  1'b1, 5'd15, 14'h0000, 1'b0, 16'h8000, 2);
        run_op("expo0",    1'b0, 5'd0,  14'h1000, 1'b0, 16'h0400, 3);

        // start held high across the busy window: only one result may appear
        @(negedge clk);
        in_sign = 1'b0; in_expo = 5'd15; in_sig = 14'h1000; in_sticky = 1'b0; start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("hold_pulses", pulses, 1);
        check("hold_out", {16'd0, out}, 32'h3C00);

        // reset in the middle of normalization
        @(negedge clk);
        in_sign = 1'b0; in_expo = 5'd15; in_sig = 14'h0400; in_sticky = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_vld",  {31'd0, out_valid}, 32'd0);
        check("abort_out",  {16'd0, out}, 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("abort_nopulse", pulses, 0);
        run_op("after_rst", 1'b1, 5'd15, 14'h3000, 1'b0, 16'hC200, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
